sysex_patch_dump: RTL and testbench
===================================

Name: sysex_patch_dump

Overview:
- Bus master on the synth-engine parameter bus.
- On request, walks every pitch parameter (per-oscillator coarse/fine tune, key scale, base coarse/fine, and common pitch-bend range) by issuing read strobes, and captures each returned byte.
- Frames the captured bytes into a MIDI SysEx patch-dump message and hands it byte-by-byte to the MIDI transmit UART.
- Sits between the engine's parameter registers and the MIDI out path.

Parameters:
- NUM_OSC, 4, oscillators per voice; each owns a 16-address block at adr = osc<<4.
- MFR_ID, 8'h7D, SysEx manufacturer byte (bit 7 must be 0).
- DEV_ID, 8'h00, SysEx device byte (bit 7 must be 0).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_reg_N  in  1  asynchronous, active-low reset.
- dump_req  in  1  single-cycle start pulse.
- busy  out  1  high from the accepted dump_req until the F7 byte is accepted.
- done  out  1  one-cycle pulse after the F7 byte is accepted.
- sysex_data_patch_send  out  1  enables responders to drive the data bus; equals busy.
- adr  out  7  parameter address.
- osc_sel  out  1  oscillator-block select.
- com_sel  out  1  common-block select.
- read  out  1  read strobe; responders latch on its rising edge.
- data_in  in  8  parameter data bus (input side of the shared inout).
- tx_data  out  8  byte to the UART.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts when tx_valid && tx_ready at a rising clk.

Behaviour:
- Reset (async assert): every output = 0; state = IDLE; counters and checksum = 0. Release is synchronous to clk.
- The block never drives write. osc_sel and com_sel are never high together. adr, osc_sel and com_sel are stable for the whole read sequence.
- Byte order: F0, MFR_ID, DEV_ID, then parameters, then CHK, then F7.
  - Oscillator parameters: for osc 0..NUM_OSC-1, offsets 0, 1, 5, 8, 9 (adr = offset + (osc<<4), osc_sel=1).
  - Common parameter: pb_range (adr=0, com_sel=1).
  - Total length = 3 + 5*NUM_OSC + 1 + 2 bytes = 26 at the default NUM_OSC.
- Parameter bytes are sent as data_in[6:0], with bit 7 forced to 0.
- CHK = (128 - (sum of sent parameter bytes mod 128)) mod 128, computed over a 7-bit accumulator.
- States:
  - IDLE: on dump_req, go to HDR; busy=1.
  - HDR: present F0, MFR_ID, DEV_ID in turn; advance on each accept. After DEV_ID, go to SEL.
  - SEL: drive adr and select for one cycle; read=0.
  - RDH1, RDH2: read=1 for two cycles.
  - CAP: read=0; register data_in[6:0]; add it to the checksum.
  - SEND: present the captured byte. On accept, step the offset index and then the oscillator index, and go to SEL. After the last oscillator, do the common read (SEL..SEND with com_sel). After the common byte, go to CHK.
  - CHK: present the checksum; on accept, go to EOX.
  - EOX: present F7; on accept, go to DONE.
  - DONE: done=1 for one cycle, busy=0; go to IDLE.
- Handshake:
  - tx_valid rises in the state that presents a byte.
  - tx_valid and tx_data are held stable until accepted.
  - tx_valid drops in the cycle after acceptance unless the next byte is immediately ready; header bytes may go back-to-back.
  - tx_ready held low stalls the FSM indefinitely with no loss.
- Minimum latency per parameter: 4 cycles (SEL, RDH1, RDH2, CAP) plus the UART accept.
- Boundaries:
  - dump_req while busy is ignored.
  - dump_req in the same cycle as DONE is ignored; a new request needs busy=0.
  - tx_ready high in the same cycle tx_valid rises counts as an accept.
  - Reset mid-dump aborts immediately: all outputs go to 0, no F7 is sent, and the checksum is cleared.
  - data_in bit 7 set: the byte is masked to 7 bits and the masked value enters the checksum.

Decomposition:
- Shared package (synth_bus_pkg):
  - SYSEX_SOX = 8'hF0 and SYSEX_EOX = 8'hF7.
  - OSC_PARAM_OFFS array {0,1,5,8,9} and OSC_PARAM_CNT = 5.
  - OSC_BLOCK_SHIFT = 4 and COM_PB_RANGE_ADR = 0.
  - The FSM state enum.
- One natural sub-module, sysex_checksum (7-bit clear/accumulate/result), reusable by the SysEx receiver.

Test Plan:
- Reset-default registers (ct/ft/bct/bft = 0x40, kscale = 0, pb_range = 3), tx_ready tied high → exactly 26 bytes: F0 7D 00, then per osc 40 40 00 40 40, then 03, then CHK = 7D, then F7. One done pulse follows.
- Per read: check osc_sel=1 and adr sequence 0,1,5,8,9,16,17,21,24,25,32,…,57. Then com_sel=1 with adr=0. read is high for exactly 2 cycles, preceded by 1 setup cycle.
- tx_ready random 30% duty → identical byte stream; tx_data never changes while tx_valid=1 && tx_ready=0.
- osc1 fine = 0xC5 → byte sent 0x45; checksum recomputed with 0x45; CHK matches the formula.
- Pulse dump_req at byte 10 of a dump → ignored; stream unchanged; busy stays high; exactly one done.
- Assert reset_reg_N=0 at byte 12 → all outputs 0 asynchronously. A new dump after release starts at F0 with the default-data checksum 7D.

Source files
------------

// File: rtl/synth_bus_pkg.sv
// Shared definitions for the synth-engine parameter bus and SysEx framing.
// Holds SysEx framing bytes, pitch-parameter address map and dump FSM states.
package synth_bus_pkg;

    localparam logic [7:0] SYSEX_SOX = 8'hF0;
    localparam logic [7:0] SYSEX_EOX = 8'hF7;

    localparam int OSC_PARAM_CNT = 5;
    // Entry [0] is offset 0: coarse, fine, key scale, base coarse, base fine.
    localparam logic [OSC_PARAM_CNT-1:0][3:0] OSC_PARAM_OFFS =
        {4'd9, 4'd8, 4'd5, 4'd1, 4'd0};

    localparam int         OSC_BLOCK_SHIFT  = 4;
    localparam logic [6:0] COM_PB_RANGE_ADR = 7'd0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEL,
        ST_RDH1,
        ST_RDH2,
        ST_CAP,
        ST_SEND,
        ST_CHK,
        ST_EOX,
        ST_DONE
    } dump_state_e;

    function automatic logic [6:0] osc_param_adr(
        input logic [2:0] osc,
        input logic [2:0] idx
    );
        return (7'(osc) << OSC_BLOCK_SHIFT) + 7'(OSC_PARAM_OFFS[idx]);
    endfunction

endpackage

// File: rtl/sysex_checksum.sv
// 7-bit SysEx checksum: clear, accumulate, and two's-complement result.
// Ports: clk_i, rst_ni, clr_i, acc_en_i, data_i[6:0] in; chk_o[6:0] out.
module sysex_checksum (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       acc_en_i,
    input  logic [6:0] data_i,
    output logic [6:0] chk_o
);

    logic [6:0] sum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= 7'd0;
        end else if (clr_i) begin
            sum_q <= 7'd0;
        end else if (acc_en_i) begin
            sum_q <= sum_q + data_i;
        end
    end

    // (128 - sum mod 128) mod 128 is simply the 7-bit negation.
    assign chk_o = 7'd0 - sum_q;

endmodule

// File: rtl/sysex_patch_dump.sv
// Reads all pitch parameters over the synth parameter bus and streams
// them to the MIDI UART as a SysEx patch dump (F0 mfr dev data chk F7).
// Ports: clk, reset_reg_N, dump_req, data_in[7:0], tx_ready in;
//        busy, done, sysex_data_patch_send, adr[6:0], osc_sel, com_sel,
//        read, tx_data[7:0], tx_valid out.
module sysex_patch_dump
    import synth_bus_pkg::*;
#(
    parameter int         NUM_OSC = 4,
    parameter logic [7:0] MFR_ID  = 8'h7D,
    parameter logic [7:0] DEV_ID  = 8'h00
) (
    input  logic       clk,
    input  logic       reset_reg_N,
    input  logic       dump_req,
    output logic       busy,
    output logic       done,
    output logic       sysex_data_patch_send,
    output logic [6:0] adr,
    output logic       osc_sel,
    output logic       com_sel,
    output logic       read,
    input  logic [7:0] data_in,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    dump_state_e state_q;
    logic        busy_q;
    logic        done_q;
    logic [6:0]  adr_q;
    logic        osc_sel_q;
    logic        com_sel_q;
    logic        read_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic [1:0]  hdr_q;
    logic [2:0]  osc_q;
    logic [2:0]  off_q;

    logic        accept;
    logic        chk_clr;
    logic        chk_acc;
    logic [6:0]  chk;

    assign accept  = tx_valid_q & tx_ready;
    assign chk_clr = (state_q == ST_IDLE && dump_req) ||
                     (state_q == ST_DONE);
    assign chk_acc = (state_q == ST_CAP);

    sysex_checksum u_chk (
        .clk_i    (clk),
        .rst_ni   (reset_reg_N),
        .clr_i    (chk_clr),
        .acc_en_i (chk_acc),
        .data_i   (data_in[6:0]),
        .chk_o    (chk)
    );

    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            adr_q      <= 7'd0;
            osc_sel_q  <= 1'b0;
            com_sel_q  <= 1'b0;
            read_q     <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            hdr_q      <= 2'd0;
            osc_q      <= 3'd0;
            off_q      <= 3'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (dump_req) begin
                        busy_q     <= 1'b1;
                        tx_data_q  <= SYSEX_SOX;
                        tx_valid_q <= 1'b1;
                        hdr_q      <= 2'd0;
                        osc_q      <= 3'd0;
                        off_q      <= 3'd0;
                        state_q    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        unique case (hdr_q)
                            2'd0: begin
                                tx_data_q <= MFR_ID;
                                hdr_q     <= 2'd1;
                            end
                            2'd1: begin
                                tx_data_q <= DEV_ID;
                                hdr_q     <= 2'd2;
                            end
                            default: begin
                                tx_valid_q <= 1'b0;
                                adr_q      <= osc_param_adr(3'd0, 3'd0);
                                osc_sel_q  <= 1'b1;
                                state_q    <= ST_SEL;
                            end
                        endcase
                    end
                end
                ST_SEL: begin
                    read_q  <= 1'b1;
                    state_q <= ST_RDH1;
                end
                ST_RDH1: begin
                    state_q <= ST_RDH2;
                end
                ST_RDH2: begin
                    read_q  <= 1'b0;
                    state_q <= ST_CAP;
                end
                ST_CAP: begin
                    tx_data_q  <= {1'b0, data_in[6:0]};
                    tx_valid_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (accept) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= ST_SEL;
                        if (com_sel_q) begin
                            // Common byte was last; checksum already holds it.
                            com_sel_q  <= 1'b0;
                            tx_data_q  <= {1'b0, chk};
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_CHK;
                        end else if (off_q == 3'(OSC_PARAM_CNT - 1)) begin
                            off_q <= 3'd0;
                            if (osc_q == 3'(NUM_OSC - 1)) begin
                                osc_sel_q <= 1'b0;
                                com_sel_q <= 1'b1;
                                adr_q     <= COM_PB_RANGE_ADR;
                            end else begin
                                osc_q <= osc_q + 3'd1;
                                adr_q <= osc_param_adr(osc_q + 3'd1, 3'd0);
                            end
                        end else begin
                            off_q <= off_q + 3'd1;
                            adr_q <= osc_param_adr(osc_q, off_q + 3'd1);
                        end
                    end
                end
                ST_CHK: begin
                    if (accept) begin
                        tx_data_q <= SYSEX_EOX;
                        state_q   <= ST_EOX;
                    end
                end
                ST_EOX: begin
                    if (accept) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= 8'd0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        adr_q      <= 7'd0;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign sysex_data_patch_send = busy_q;
    assign adr                   = adr_q;
    assign osc_sel               = osc_sel_q;
    assign com_sel               = com_sel_q;
    assign read                  = read_q;
    assign tx_data               = tx_data_q;
    assign tx_valid              = tx_valid_q;

endmodule

// File: tb/tb_sysex_patch_dump.sv
// Directed bench for sysex_patch_dump with a parameter-register responder.
// Checks byte stream, read-bus sequencing, handshake stalls and reset abort.
module tb_sysex_patch_dump;

    logic       clk = 1'b0;
    logic       reset_reg_N;
    logic       dump_req;
    logic       busy;
    logic       done;
    logic       send;
    logic [6:0] adr;
    logic       osc_sel;
    logic       com_sel;
    logic       read;
    logic [7:0] data_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    sysex_patch_dump dut (
        .clk                   (clk),
        .reset_reg_N           (reset_reg_N),
        .dump_req              (dump_req),
        .busy                  (busy),
        .done                  (done),
        .sysex_data_patch_send (send),
        .adr                   (adr),
        .osc_sel               (osc_sel),
        .com_sel               (com_sel),
        .read                  (read),
        .data_in               (data_in),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready)
    );

    always #5 clk = ~clk;

    logic [7:0] osc_mem [128];
    logic [7:0] pb_range;
    logic [7:0] lat;

    always @(posedge read) lat = com_sel ? pb_range : osc_mem[adr];
    assign data_in = send ? lat : 8'h00;

    int n_cmp = 0;
    int n_err = 0;
    int rdy_mode = 0;

    logic [7:0] tx_q [$];
    logic [8:0] rd_q [$];
    int stall_viol, setup_viol, rdlen_viol, sel_viol, done_cnt, run;
    logic pv, pr, p_read;
    logic [7:0] pd;
    logic [6:0] p_adr;

    initial begin
        stall_viol = 0; setup_viol = 0; rdlen_viol = 0;
        sel_viol = 0; done_cnt = 0; run = 0;
        pv = 0; pr = 0; p_read = 0; pd = 0; p_adr = 0;
    end

    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (pv && !pr && (!tx_valid || tx_data !== pd)) stall_viol++;
        if (read && !p_read) begin
            rd_q.push_back({osc_sel, com_sel, adr});
            if (adr !== p_adr) setup_viol++;
            run = 1;
        end else if (read) begin
            run++;
        end else if (p_read && run != 2) begin
            rdlen_viol++;
        end
        if (osc_sel && com_sel) sel_viol++;
        if (done) done_cnt++;
        pv = tx_valid; pr = tx_ready; pd = tx_data;
        p_read = read; p_adr = adr;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
        end
    end

    logic [7:0] exp_def [26] = '{
        8'hF0, 8'h7D, 8'h00,
        8'h40, 8'h40, 8'h00, 8'h40, 8'h40,
        8'h40, 8'h40, 8'h00, 8'h40, 8'h40,
        8'h40, 8'h40, 8'h00, 8'h40, 8'h40,
        8'h40, 8'h40, 8'h00, 8'h40, 8'h40,
        8'h03, 8'h7D, 8'hF7
    };
    logic [7:0] exp_s [26];
    logic [6:0] exp_adr [20] = '{
        7'd0,  7'd1,  7'd5,  7'd8,  7'd9,
        7'd16, 7'd17, 7'd21, 7'd24, 7'd25,
        7'd32, 7'd33, 7'd37, 7'd40, 7'd41,
        7'd48, 7'd49, 7'd53, 7'd56, 7'd57
    };

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_defaults();
        for (int i = 0; i < 128; i++) osc_mem[i] = 8'hEE;
        for (int o = 0; o < 4; o++) begin
            osc_mem[o*16 + 0] = 8'h40;
            osc_mem[o*16 + 1] = 8'h40;
            osc_mem[o*16 + 5] = 8'h00;
            osc_mem[o*16 + 8] = 8'h40;
            osc_mem[o*16 + 9] = 8'h40;
        end
        pb_range = 8'h03;
    endtask

    function automatic logic [31:0] outs();
        return 32'({busy, done, send, adr, osc_sel, com_sel,
                    read, tx_data, tx_valid});
    endfunction

    // kind: 0 plain, 1 dump_req at byte inj, 2 reset at byte inj
    task automatic run_dump(input string tag, input int kind, input int inj);
        int dn0;
        bit fired;
        tx_q.delete();
        rd_q.delete();
        stall_viol = 0; setup_viol = 0; rdlen_viol = 0; sel_viol = 0;
        dn0 = done_cnt;
        fired = 0;
        dump_req = 1'b1;
        @(posedge clk);
        #1;
        dump_req = 1'b0;
        for (int i = 0; i < 4000 && done_cnt == dn0; i++) begin
            @(posedge clk);
            #1;
            dump_req = 1'b0;
            if (kind != 0 && !fired && tx_q.size() == inj) begin
                fired = 1;
                if (kind == 1) begin
                    chk({tag, "_busy_at_req"}, 32'(busy), 32'd1);
                    dump_req = 1'b1;
                end else begin
                    reset_reg_N = 1'b0;
                    #1;
                    chk({tag, "_async_zero"}, outs(), 32'd0);
                    return;
                end
            end
        end
        chk({tag, "_done_seen"}, 32'(done_cnt - dn0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_one_done"}, 32'(done_cnt - dn0), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 32'(tx_q.size()), 32'd26);
        for (int i = 0; i < 26; i++)
            if (i < tx_q.size())
                chk($sformatf("%s_b%0d", tag, i), 32'(tx_q[i]), 32'(exp_s[i]));
        chk({tag, "_stall"}, 32'(stall_viol), 32'd0);
        chk({tag, "_sel_excl"}, 32'(sel_viol), 32'd0);
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_nreads"}, 32'(rd_q.size()), 32'd21);
        for (int i = 0; i < 21; i++)
            if (i < rd_q.size())
                chk($sformatf("%s_rd%0d", tag, i), 32'(rd_q[i]),
                    (i < 20) ? 32'({2'b10, exp_adr[i]}) : 32'({2'b01, 7'd0}));
        chk({tag, "_rdlen"}, 32'(rdlen_viol), 32'd0);
        chk({tag, "_setup"}, 32'(setup_viol), 32'd0);
    endtask

    initial begin
        reset_reg_N = 1'b0;
        dump_req = 1'b0;
        tx_ready = 1'b1;
        set_defaults();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 32'd0);
        reset_reg_N = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_outs", outs(), 32'd0);

        exp_s = exp_def;
        run_dump("dflt", 0, 0);
        check_stream("dflt");
        check_reads("dflt");

        rdy_mode = 1;
        run_dump("rnd", 0, 0);
        check_stream("rnd");
        check_reads("rnd");

        rdy_mode = 0;
        osc_mem[17] = 8'hC5;
        exp_s = exp_def;
        exp_s[9] = 8'h45;
        exp_s[24] = 8'h78;
        run_dump("bit7", 0, 0);
        check_stream("bit7");

        set_defaults();
        exp_s = exp_def;
        rdy_mode = 1;
        run_dump("busyreq", 1, 10);
        check_stream("busyreq");

        rdy_mode = 0;
        run_dump("rstmid", 2, 12);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_outs", outs(), 32'd0);
        reset_reg_N = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rel_outs", outs(), 32'd0);
        run_dump("after_rst", 0, 0);
        check_stream("after_rst");
        check_reads("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
